// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: drives a single-outstanding fetch handshake and redirects on taken branch/jump.
// Request issues 1 cycle after reset; a held instruction under stall blocks new requests; flush overrides stall.
module pc_redirect_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            br_valid,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic            cond_ok,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic            stall,
  output logic            fetch_req,
  output logic [XLEN-1:0] fetch_addr,
  input  logic            fetch_gnt,
  input  logic            fetch_rvalid,
  input  logic [31:0]     fetch_rdata,
  output logic            inst_valid,
  output logic [31:0]     inst_out,
  output logic [XLEN-1:0] inst_pc,
  output logic            flush,
  output logic [XLEN-1:0] link_addr,
  output logic            misalign
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] target_sum, target;
  logic            taken, aligned, accept, capture;

  assign taken      = br_valid & ((is_branch & cond_ok) | is_jal | is_jalr);
  assign target_sum = (is_jalr ? rs1 : br_pc) + imm;
  assign target     = is_jalr ? {target_sum[XLEN-1:1], 1'b0} : target_sum;
  assign aligned    = (target[1:0] == 2'b00);
  assign flush      = taken & aligned;
  assign link_addr  = br_pc + XLEN'(4);
  assign fetch_addr = pc;

  assign accept  = fetch_req & fetch_gnt;
  assign capture = (state == S_WAIT) & fetch_rvalid & ~flush;

  always_comb begin
    state_nxt = state;
    fetch_req = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        fetch_req = ~inst_valid | ~stall;
        if (fetch_req && fetch_gnt) state_nxt = flush ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        // A response arriving with the flush is dropped here; otherwise the DROP state eats it later.
        if (fetch_rvalid)  state_nxt = S_REQ;
        else if (flush)    state_nxt = S_DROP;
      end
      S_DROP: if (fetch_rvalid) state_nxt = S_REQ;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pc_nxt = pc;
    if (flush)       pc_nxt = target;
    else if (accept) pc_nxt = pc + XLEN'(4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      inst_valid <= 1'b0;
      inst_out   <= '0;
      inst_pc    <= '0;
      misalign   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      misalign <= taken & ~aligned;
      if (flush) begin
        inst_valid <= 1'b0;
      end else if (capture) begin
        inst_valid <= 1'b1;
        inst_out   <= fetch_rdata;
        inst_pc    <= pc - XLEN'(4);
      end else if (!stall) begin
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: sequential fetch, redirects, misalignment, stall and reset.
module tb_pc_redirect_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            br_valid = 1'b0, is_branch = 1'b0, is_jal = 1'b0, is_jalr = 1'b0, cond_ok = 1'b0;
  logic [XLEN-1:0] br_pc = '0, imm = '0, rs1 = '0;
  logic            stall = 1'b0;
  logic            fetch_req;
  logic [XLEN-1:0] fetch_addr;
  logic            fetch_gnt = 1'b0, fetch_rvalid = 1'b0;
  logic [31:0]     fetch_rdata = '0;
  logic            inst_valid;
  logic [31:0]     inst_out;
  logic [XLEN-1:0] inst_pc;
  logic            flush;
  logic [XLEN-1:0] link_addr;
  logic            misalign;

  int checks = 0;
  int passed = 0;

  pc_redirect_unit #(.XLEN(XLEN), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .br_valid(br_valid), .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
    .cond_ok(cond_ok), .br_pc(br_pc), .imm(imm), .rs1(rs1), .stall(stall),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
    .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc),
    .flush(flush), .link_addr(link_addr), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_br();
    br_valid = 1'b0; is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0; cond_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    checks++; if ({fetch_req, inst_valid, misalign} !== 3'b000) $display("FAIL reset_ctrl: got %b want 000", {fetch_req, inst_valid, misalign}); else passed++;
    checks++; if (fetch_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", fetch_addr); else passed++;
    checks++; if ({inst_out, inst_pc} !== 64'h0) $display("FAIL reset_inst: got %h/%h want 0/0", inst_out, inst_pc); else passed++;
    rst_n = 1'b1;
    #1;
    checks++; if (fetch_req !== 1'b0) $display("FAIL idle_req: got %b want 0", fetch_req); else passed++;
    step();
    checks++; if (fetch_req !== 1'b1) $display("FAIL first_req: got %b want 1", fetch_req); else passed++;
  endtask

  task automatic test_seq_fetch();
    for (int i = 0; i < 3; i++) begin
      checks++; if (fetch_addr !== 32'(i * 4)) $display("FAIL seq_addr%0d: got %h want %h", i, fetch_addr, 32'(i * 4)); else passed++;
      fetch_gnt = 1'b1;
      step();
      fetch_gnt = 1'b0;
      checks++; if (fetch_req !== 1'b0) $display("FAIL seq_wait_req%0d: got %b want 0", i, fetch_req); else passed++;
      fetch_rvalid = 1'b1; fetch_rdata = 32'hA000_0000 + 32'(i);
      step();
      fetch_rvalid = 1'b0;
      checks++; if (inst_valid !== 1'b1) $display("FAIL seq_valid%0d: got %b want 1", i, inst_valid); else passed++;
      checks++; if (inst_pc !== 32'(i * 4)) $display("FAIL seq_pc%0d: got %h want %h", i, inst_pc, 32'(i * 4)); else passed++;
      checks++; if (inst_out !== 32'hA000_0000 + 32'(i)) $display("FAIL seq_data%0d: got %h want %h", i, inst_out, 32'hA000_0000 + 32'(i)); else passed++;
    end
  endtask

  // pc=0xC in REQ on entry.
  task automatic test_beq_flush();
    fetch_gnt = 1'b1;
    step();
    fetch_gnt = 1'b0;
    br_valid = 1'b1; is_branch = 1'b1; cond_ok = 1'b1; br_pc = 32'h20; imm = 32'h10;
    #1;
    checks++; if (flush !== 1'b1) $display("FAIL beq_flush: got %b want 1", flush); else passed++;
    step();
    clear_br();
    #1;
    checks++; if ({flush, fetch_req, inst_valid} !== 3'b000) $display("FAIL beq_drop: got %b want 000", {flush, fetch_req, inst_valid}); else passed++;
    checks++; if (fetch_addr !== 32'h30) $display("FAIL beq_target: got %h want 30", fetch_addr); else passed++;
    fetch_rvalid = 1'b1; fetch_rdata = 32'hDEAD_BEEF;
    step();
    fetch_rvalid = 1'b0;
    checks++; if (inst_valid !== 1'b0) $display("FAIL beq_discard: got %b want 0", inst_valid); else passed++;
    checks++; if ({fetch_req, fetch_addr} !== {1'b1, 32'h30}) $display("FAIL beq_refetch: got %b/%h want 1/30", fetch_req, fetch_addr); else passed++;
    fetch_gnt = 1'b1;
    step();
    fetch_gnt = 1'b0; fetch_rvalid = 1'b1; fetch_rdata = 32'h1234_5678;
    step();
    fetch_rvalid = 1'b0;
    checks++; if ({inst_valid, inst_pc} !== {1'b1, 32'h30}) $display("FAIL beq_capture: got %b/%h want 1/30", inst_valid, inst_pc); else passed++;
  endtask

  // pc=0x34 in REQ on entry.
  task automatic test_not_taken();
    br_valid = 1'b1; is_branch = 1'b1; cond_ok = 1'b0; br_pc = 32'h80; imm = 32'h40;
    #1;
    checks++; if (flush !== 1'b0) $display("FAIL nt_flush: got %b want 0", flush); else passed++;
    step();
    clear_br();
    checks++; if ({fetch_req, fetch_addr} !== {1'b1, 32'h34}) $display("FAIL nt_pc: got %b/%h want 1/34", fetch_req, fetch_addr); else passed++;
  endtask

  task automatic test_jalr();
    br_valid = 1'b1; is_jalr = 1'b1; rs1 = 32'h101; imm = 32'h4; br_pc = 32'h40;
    #1;
    checks++; if (flush !== 1'b1) $display("FAIL jalr_flush: got %b want 1", flush); else passed++;
    checks++; if (link_addr !== 32'h44) $display("FAIL jalr_link: got %h want 44", link_addr); else passed++;
    step();
    clear_br();
    checks++; if (fetch_addr !== 32'h104) $display("FAIL jalr_target: got %h want 104", fetch_addr); else passed++;
    checks++; if (misalign !== 1'b0) $display("FAIL jalr_misalign: got %b want 0", misalign); else passed++;
  endtask

  task automatic test_jal_misalign();
    br_valid = 1'b1; is_jal = 1'b1; br_pc = 32'h100; imm = 32'h2;
    #1;
    checks++; if (flush !== 1'b0) $display("FAIL mis_flush: got %b want 0", flush); else passed++;
    step();
    clear_br();
    checks++; if (misalign !== 1'b1) $display("FAIL mis_pulse: got %b want 1", misalign); else passed++;
    checks++; if (fetch_addr !== 32'h104) $display("FAIL mis_pc: got %h want 104", fetch_addr); else passed++;
    step();
    checks++; if (misalign !== 1'b0) $display("FAIL mis_clear: got %b want 0", misalign); else passed++;
  endtask

  task automatic test_stall();
    fetch_gnt = 1'b1;
    step();
    fetch_gnt = 1'b0; fetch_rvalid = 1'b1; fetch_rdata = 32'hCAFE_F00D; stall = 1'b1;
    step();
    fetch_rvalid = 1'b0;
    checks++; if ({inst_valid, inst_out} !== {1'b1, 32'hCAFE_F00D}) $display("FAIL stall_capture: got %b/%h want 1/cafef00d", inst_valid, inst_out); else passed++;
    checks++; if (fetch_req !== 1'b0) $display("FAIL stall_req: got %b want 0", fetch_req); else passed++;
    step();
    checks++; if ({inst_valid, inst_out, inst_pc} !== {1'b1, 32'hCAFE_F00D, 32'h104}) $display("FAIL stall_hold: got %b/%h/%h want 1/cafef00d/104", inst_valid, inst_out, inst_pc); else passed++;
    br_valid = 1'b1; is_jal = 1'b1; br_pc = 32'h200; imm = 32'h40;
    #1;
    checks++; if (flush !== 1'b1) $display("FAIL stall_flush: got %b want 1", flush); else passed++;
    step();
    clear_br();
    stall = 1'b0;
    checks++; if (inst_valid !== 1'b0) $display("FAIL stall_kill: got %b want 0", inst_valid); else passed++;
    checks++; if ({fetch_req, fetch_addr} !== {1'b1, 32'h240}) $display("FAIL stall_redirect: got %b/%h want 1/240", fetch_req, fetch_addr); else passed++;
  endtask

  task automatic test_wrap();
    br_valid = 1'b1; is_branch = 1'b1; cond_ok = 1'b1; br_pc = 32'hFFFF_FFFC; imm = 32'h8;
    #1;
    checks++; if (link_addr !== 32'h0) $display("FAIL wrap_link: got %h want 0", link_addr); else passed++;
    step();
    clear_br();
    checks++; if (fetch_addr !== 32'h4) $display("FAIL wrap_target: got %h want 4", fetch_addr); else passed++;
  endtask

  task automatic test_back_to_back();
    // Grant and redirect in the same cycle: the granted request must be dropped.
    fetch_gnt = 1'b1; br_valid = 1'b1; is_jal = 1'b1; br_pc = 32'h300; imm = 32'h10;
    step();
    fetch_gnt = 1'b0; clear_br();
    checks++; if ({fetch_req, fetch_addr} !== {1'b0, 32'h310}) $display("FAIL gntflush_drop: got %b/%h want 0/310", fetch_req, fetch_addr); else passed++;
    fetch_rvalid = 1'b1; fetch_rdata = 32'hBAD0_0001;
    step();
    fetch_rvalid = 1'b0;
    checks++; if ({inst_valid, fetch_req, fetch_addr} !== {1'b0, 1'b1, 32'h310}) $display("FAIL gntflush_req: got %b/%b/%h want 0/1/310", inst_valid, fetch_req, fetch_addr); else passed++;
    fetch_gnt = 1'b1;
    step();
    fetch_gnt = 1'b0;
    fetch_rvalid = 1'b1; fetch_rdata = 32'hBAD0_0002; br_valid = 1'b1; is_jal = 1'b1; br_pc = 32'h400; imm = 32'h20;
    step();
    fetch_rvalid = 1'b0; clear_br();
    checks++; if ({inst_valid, fetch_req, fetch_addr} !== {1'b0, 1'b1, 32'h420}) $display("FAIL rvflush: got %b/%b/%h want 0/1/420", inst_valid, fetch_req, fetch_addr); else passed++;
  endtask

  task automatic test_mid_reset();
    fetch_gnt = 1'b1;
    step();
    fetch_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if ({inst_valid, fetch_req} !== 2'b00) $display("FAIL mrst_ctrl: got %b want 00", {inst_valid, fetch_req}); else passed++;
    checks++; if (fetch_addr !== 32'h0) $display("FAIL mrst_addr: got %h want 0", fetch_addr); else passed++;
    checks++; if ({inst_out, inst_pc} !== 64'h0) $display("FAIL mrst_inst: got %h/%h want 0/0", inst_out, inst_pc); else passed++;
    step();
    rst_n = 1'b1;
    step();
    checks++; if ({fetch_req, fetch_addr} !== {1'b1, 32'h0}) $display("FAIL mrst_restart: got %b/%h want 1/0", fetch_req, fetch_addr); else passed++;
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_beq_flush();
    test_not_taken();
    test_jalr();
    test_jal_misalign();
    test_stall();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
